spi_slave: RTL

Oversampled SPI slave (responder) for the active-suspension controller's sensor/host links. Runs entirely on the system clock. Samples the external `sclk`, `cs` and `mosi` through synchronizers and recovers bus edges from them. Shifts a `SPI_BITS`-bit word in from `mosi` while shifting `data_tx` out on `miso`, in the same CPOL/CPHA convention as the team's `spi_master`. Delivers each received word with a one-cycle valid strobe.

---
 rtl/spi_slave_if.sv | 21 ++
 rtl/spi_slave.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI bus pins between an external master and the spi_slave responder.
interface spi_slave_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (
        output sclk,
        output cs,
        output mosi,
        input  miso
    );

    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/spi_slave.sv
// Oversampled SPI slave: synchronizes sclk/cs/mosi onto the system clock,
// recovers bus edges and shifts one SPI_BITS-bit word per frame slot.
module spi_slave #(
    parameter bit          CPOL     = 1'b1,
    parameter bit          CPHA     = 1'b1,
    parameter int unsigned SPI_BITS = 16
) (
    input  logic                clk_spi_drive,
    input  logic                rst,
    input  logic                enable,
    spi_slave_if.slave          bus,
    input  logic [SPI_BITS-1:0] data_tx,
    output logic [SPI_BITS-1:0] data_rx,
    output logic                rx_valid,
    output logic                busy,
    output logic                frame_err
);

    localparam int unsigned CNT_W = (SPI_BITS > 2) ? $clog2(SPI_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic                sclk_meta, sclk_s, sclk_prev;
    logic                cs_meta, cs_s, cs_prev;
    logic                mosi_meta, mosi_s;
    logic [SPI_BITS-1:0] shift_tx;
    logic [SPI_BITS-1:0] shift_rx;
    logic [SPI_BITS-1:0] rx_word;
    logic [CNT_W-1:0]    bit_cnt;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, word_done, word_open;

    // Two-flop synchronizers plus a history flop for edge detection
    always_ff @(posedge clk_spi_drive) begin
        if (rst) begin
            sclk_meta <= CPOL;
            sclk_s    <= CPOL;
            sclk_prev <= CPOL;
            cs_meta   <= 1'b1;
            cs_s      <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sclk_meta <= bus.sclk;
            sclk_s    <= sclk_meta;
            sclk_prev <= sclk_s;
            cs_meta   <= bus.cs;
            cs_s      <= cs_meta;
            cs_prev   <= cs_s;
            mosi_meta <= bus.mosi;
            mosi_s    <= mosi_meta;
        end
    end

    // Bus edge recovery; sample/shift roles swap with CPHA
    assign lead_edge   = (sclk_prev == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_prev != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign cs_fall     = cs_prev && !cs_s;
    assign cs_rise     = !cs_prev && cs_s;

    // Word assembly; a sample coinciding with cs rise is folded in first
    assign rx_word   = SPI_BITS'({shift_rx, mosi_s});
    assign word_done = sample_edge && (bit_cnt == LAST_BIT);
    assign word_open = sample_edge ? !word_done : (bit_cnt != '0);

    // Frame state machine with registered bus and status outputs
    always_ff @(posedge clk_spi_drive) begin
        if (rst) begin
            state     <= IDLE;
            shift_tx  <= '0;
            shift_rx  <= '0;
            bit_cnt   <= '0;
            bus.miso  <= 1'b0;
            data_rx   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                busy     <= 1'b0;
                bus.miso <= 1'b0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        busy     <= 1'b0;
                        bus.miso <= 1'b0;
                        if (cs_fall) begin
                            state   <= SHIFT;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                            if (!CPHA) begin
                                // MSB goes out before the first clock edge
                                bus.miso <= data_tx[SPI_BITS-1];
                                shift_tx <= data_tx << 1;
                            end else begin
                                shift_tx <= data_tx;
                            end
                        end
                    end
                    SHIFT: begin
                        if (shift_edge) begin
                            bus.miso <= shift_tx[SPI_BITS-1];
                            shift_tx <= shift_tx << 1;
                        end
                        if (sample_edge) begin
                            shift_rx <= rx_word;
                            if (word_done) begin
                                data_rx  <= rx_word;
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                                shift_tx <= data_tx;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (cs_rise) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            bus.miso  <= 1'b0;
                            bit_cnt   <= '0;
                            frame_err <= word_open;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        bus.miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
